// File: rtl/conv_sample_mem_if.sv
// Bus bundle for conv_sample_mem: host write/read, append load, clear,
// stream launch and the valid/ready sample stream into the MAC stage.
interface conv_sample_mem_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
);
  logic                  clear;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  push_en;
  logic [DATA_WIDTH-1:0] push_data;
  logic                  push_drop;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  start;
  logic [ADDR_WIDTH-1:0] start_idx;
  logic [LEN_WIDTH-1:0]  len;
  logic                  out_valid;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_last;
  logic                  out_ready;
  logic                  busy;
  logic [ADDR_WIDTH:0]   size;
  logic                  full;

  modport master (
    output clear, wr_en, wr_addr, wr_data, push_en, push_data,
           rd_en, rd_addr, start, start_idx, len, out_ready,
    input  push_drop, rd_data, out_valid, out_data, out_last, busy, size, full
  );

  modport slave (
    input  clear, wr_en, wr_addr, wr_data, push_en, push_data,
           rd_en, rd_addr, start, start_idx, len, out_ready,
    output push_drop, rd_data, out_valid, out_data, out_last, busy, size, full
  );
endinterface

// File: rtl/conv_sample_mem.sv
// Parametrised sample store for the convolution datapath: random-access
// host port, append loading with fill count, clear, and a newest-to-oldest
// replay engine that zero-pads indices outside the filled region.
module conv_sample_mem #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 10,
  parameter int ADDR_WIDTH = $clog2(DEPTH),
  parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) (
  input logic              clk,
  input logic              rst_n,
  conv_sample_mem_if.slave bus
);
  localparam int IW = ADDR_WIDTH + 2;
  localparam logic [ADDR_WIDTH:0]  DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]  SZ_ONE  = 1;
  localparam logic signed [IW-1:0] IDX_ONE = 1;
  localparam logic [LEN_WIDTH-1:0] REM_ONE = 1;

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  // Samples are only ever appended from 0 and cleared together, so the
  // append pointer always equals the fill count; size doubles as wr_ptr.
  logic [ADDR_WIDTH:0]   size;
  logic signed [IW-1:0]  idx;
  logic [LEN_WIDTH-1:0]  rem;
  logic [DATA_WIDTH-1:0] rd_q, od_q;
  logic                  ov_q, ol_q, drop_q;
  logic                  full, wr_ok, rd_ok, push_acc, idx_ok;
  logic                  launch, fetch, retire;

  assign full     = (size == DEPTH_L);
  assign wr_ok    = bus.wr_en && ({1'b0, bus.wr_addr} < DEPTH_L);
  assign rd_ok    = ({1'b0, bus.rd_addr} < DEPTH_L);
  // Single write port: clear and host writes both take precedence over appends.
  assign push_acc = bus.push_en && !bus.clear && !bus.wr_en && !full;
  // Size is sampled live so clears/appends mid-stream affect later fetches.
  assign idx_ok   = !idx[IW-1] && (idx[ADDR_WIDTH:0] < size);

  // Storage write port; contents deliberately survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_ok)         mem[bus.wr_addr] <= bus.wr_data;
    else if (push_acc) mem[size[ADDR_WIDTH-1:0]] <= bus.push_data;
  end

  // Fill count and the one-cycle drop indication for rejected appends.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      size   <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= bus.push_en && !push_acc;
      if (bus.clear)     size <= '0;
      else if (push_acc) size <= size + SZ_ONE;
    end
  end

  // Registered host read; old data wins on a same-cycle write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          rd_q <= '0;
    else if (bus.rd_en)  rd_q <= rd_ok ? mem[bus.rd_addr] : '0;
  end

  // Stream FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Stream FSM next state and per-cycle strobes.
  always_comb begin
    state_n = state;
    launch  = 1'b0;
    fetch   = 1'b0;
    retire  = 1'b0;
    case (state)
      IDLE:
        if (bus.start && bus.len != '0) begin
          launch  = 1'b1;
          state_n = RUN;
        end
      RUN:
        if (!ov_q || bus.out_ready) begin
          fetch = 1'b1;
          if (rem == REM_ONE) state_n = FLUSH;
        end
      FLUSH:
        if (ov_q && bus.out_ready) begin
          retire  = 1'b1;
          state_n = IDLE;
        end
      default: state_n = IDLE;
    endcase
  end

  // Stream datapath: index/remaining counters and the output skid register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      rem  <= '0;
      ov_q <= 1'b0;
      ol_q <= 1'b0;
      od_q <= '0;
    end else begin
      if (launch) begin
        idx <= $signed(IW'(bus.start_idx));
        rem <= bus.len;
      end
      if (fetch) begin
        od_q <= idx_ok ? mem[idx[ADDR_WIDTH-1:0]] : '0;
        ov_q <= 1'b1;
        ol_q <= (rem == REM_ONE);
        idx  <= idx - IDX_ONE;
        rem  <= rem - REM_ONE;
      end
      if (retire) begin
        ov_q <= 1'b0;
        ol_q <= 1'b0;
      end
    end
  end

  assign bus.push_drop = drop_q;
  assign bus.rd_data   = rd_q;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_last  = ol_q;
  assign bus.busy      = (state != IDLE);
  assign bus.size      = size;
  assign bus.full      = full;
endmodule
